// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants and types for the 7-segment scan bus capture block.
package seg7_scan_capture_pkg;

  // Segment patterns a..g on bits 6..0, active high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // Rightmost digit; a frame always starts here and counts down.
  localparam logic [2:0] SEL_FIRST = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // One synchronized snapshot of the scan bus.
  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dp;
  } scan_t;

endpackage

// File: rtl/seg7_scan_capture_to_bcd.sv
// Segment pattern to BCD decoder; inverse of the BCD-to-segment encoder.
// Blank is a legal pattern; anything unrecognised decodes to BCD_ERR.
module seg7_to_bcd
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  // Pattern lookup with an illegal-pattern fallthrough.
  always_comb begin
    bcd   = BCD_ERR;
    legal = 1'b1;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment scan bus observer: synchronizes the bus, samples each
// digit once it has settled, assembles frames and publishes the displayed value
// after AGREE identical error-free frames.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SETTLE     = 4,
  parameter int AGREE      = 2,
  parameter int TIMEOUT    = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              seg7_sel,
  input  logic [6:0]              seg7_out,
  input  logic                    dpt,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    value_valid,
  output logic                    update,
  output logic                    frame_done,
  output logic                    decode_err,
  output logic                    seq_err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int AW = $clog2(AGREE + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_MX = SW'(SETTLE);
  localparam logic [AW-1:0] AGREE_MX  = AW'(AGREE);
  localparam logic [WW-1:0] WD_M1     = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WD_MX     = WW'(TIMEOUT);
  localparam logic [2:0]    SEL_LAST  = 3'(6 - NUM_DIGITS);

  scan_t                          sync1, sync2, prev, last_cap;
  logic                           last_vld;
  logic [SW-1:0]                  stab_cnt;
  logic [WW-1:0]                  wd_cnt;
  logic [AW-1:0]                  agree_cnt;
  state_t                         state, state_n;
  logic [2:0]                     exp_sel;
  logic [NUM_DIGITS-1:0][3:0]     shadow, prev_good, disp;
  logic [NUM_DIGITS-1:0]          shadow_dp, prev_dp;
  logic                           err_flag;

  logic                           bus_changed, cap, wd_fire;
  logic [3:0]                     cap_bcd;
  logic                           cap_legal;
  logic [2:0]                     didx;
  logic                           start_frame, store_digit;
  logic                           same_prev, disp_differs, publish;
  logic [AW-1:0]                  agree_inc, agree_n;

  assign digits = disp;

  // Two-flop synchronizer plus one history stage for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= '{sel: seg7_sel, seg: seg7_out, dp: dpt};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign bus_changed = (sync2 != prev);

  // A settled value that matches the last capture is a re-settle after a
  // glitch, not a new digit, so it is not captured again.
  assign cap     = !bus_changed && (stab_cnt == SETTLE_M1) &&
                   !(last_vld && (sync2 == last_cap));
  assign wd_fire = !cap && (wd_cnt == WD_M1);
  assign didx    = SEL_FIRST - sync2.sel;

  seg7_to_bcd u_dec (
    .seg   (sync2.seg),
    .bcd   (cap_bcd),
    .legal (cap_legal)
  );

  // Stability counter, last-capture memory and capture watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
      wd_cnt   <= '0;
      last_cap <= '0;
      last_vld <= 1'b0;
    end else begin
      if (bus_changed)              stab_cnt <= '0;
      else if (stab_cnt != SETTLE_MX) stab_cnt <= stab_cnt + 1'b1;
      if (cap)                      wd_cnt <= '0;
      else if (wd_cnt != WD_MX)     wd_cnt <= wd_cnt + 1'b1;
      if (cap) begin
        last_cap <= sync2;
        last_vld <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state plus frame start/store strobes and sequence error.
  always_comb begin
    state_n     = state;
    seq_err     = 1'b0;
    start_frame = 1'b0;
    store_digit = 1'b0;
    case (state)
      IDLE: begin
        if (cap && sync2.sel == SEL_FIRST) begin
          start_frame = 1'b1;
          state_n     = (NUM_DIGITS == 1) ? COMMIT : COLLECT;
        end
      end
      COLLECT: begin
        if (cap) begin
          if (sync2.sel == exp_sel) begin
            store_digit = 1'b1;
            if (sync2.sel == SEL_LAST) state_n = COMMIT;
          end else if (sync2.sel == SEL_FIRST) begin
            start_frame = 1'b1;
            seq_err     = 1'b1;
          end else begin
            seq_err = 1'b1;
            state_n = IDLE;
          end
        end else if (wd_fire) begin
          state_n = IDLE;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Frame agreement and publish decision, evaluated during COMMIT.
  always_comb begin
    same_prev    = (shadow == prev_good) && (shadow_dp == prev_dp);
    disp_differs = (shadow != disp) || (shadow_dp != dp_mask);
    agree_inc    = (agree_cnt == AGREE_MX) ? agree_cnt : agree_cnt + 1'b1;
    if (err_flag)       agree_n = '0;
    else if (same_prev) agree_n = agree_inc;
    else                agree_n = AW'(1);
    publish    = !err_flag && (agree_n == AGREE_MX);
    frame_done = (state == COMMIT);
    decode_err = frame_done && err_flag;
    update     = frame_done && publish && disp_differs;
  end

  // Shadow frame assembly, agreement tracking and published value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_sel     <= SEL_FIRST;
      shadow      <= '1;
      shadow_dp   <= '0;
      err_flag    <= 1'b0;
      prev_good   <= '1;
      prev_dp     <= '0;
      agree_cnt   <= '0;
      disp        <= '1;
      dp_mask     <= '0;
      value_valid <= 1'b0;
    end else begin
      if (start_frame) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          shadow[k] <= (k == 0) ? cap_bcd : BCD_BLANK;
        shadow_dp    <= '0;
        shadow_dp[0] <= sync2.dp;
        err_flag     <= !cap_legal;
        exp_sel      <= SEL_FIRST - 3'd1;
      end else if (store_digit) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (k == int'(didx)) begin
            shadow[k]    <= cap_bcd;
            shadow_dp[k] <= sync2.dp;
          end
        end
        err_flag <= err_flag | !cap_legal;
        exp_sel  <= exp_sel - 3'd1;
      end

      if (wd_fire) begin
        value_valid <= 1'b0;
        agree_cnt   <= '0;
      end

      if (state == COMMIT) begin
        agree_cnt <= agree_n;
        if (!err_flag && !same_prev) begin
          prev_good <= shadow;
          prev_dp   <= shadow_dp;
        end
        if (publish) begin
          value_valid <= 1'b1;
          if (disp_differs) begin
            disp    <= shadow;
            dp_mask <= shadow_dp;
          end
        end
      end
    end
  end

endmodule
